// File: rtl/bpu_update_ctrl_pkg.sv
// Shared types for the branch-resolution update controller and its in-flight queue.
package bpu_update_ctrl_pkg;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
        logic        cond;
    } brq_entry_t;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } bpu_state_e;

endpackage

// File: rtl/brq_fifo.sv
// In-order queue of predicted control-transfer instructions awaiting resolution.
module brq_fifo
    import bpu_update_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_push,
    input  brq_entry_t i_push_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output brq_entry_t o_head
);

    brq_entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic                   w_push;
    logic                   w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_head];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers are exactly log2(DEPTH) wide, so increments wrap 3 -> 0 for free.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_push_data;
    end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Tracks predicted branches in flight, checks them on resolution and drives predictor
// updates, pipeline flushes and statistics.
module bpu_update_ctrl
    import bpu_update_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alloc_valid,
    input  logic [31:0] i_alloc_pc,
    input  logic        i_alloc_pred,
    input  logic [31:0] i_alloc_target,
    input  logic        i_alloc_cond,
    output logic        o_alloc_ready,
    input  logic        i_resolve_valid,
    input  logic        i_resolve_taken,
    input  logic [31:0] i_resolve_target,
    output logic        o_upd_valid,
    output logic [31:0] o_upd_pc,
    output logic        o_upd_taken,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt,
    output logic        o_err
);

    bpu_state_e  r_state;
    bpu_state_e  w_state_nxt;
    logic        r_flush;
    logic [31:0] r_redirect_pc;
    logic        r_upd_valid;
    logic [31:0] r_upd_pc;
    logic        r_upd_taken;
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;
    logic        r_err;

    logic        w_full;
    logic        w_empty;
    brq_entry_t  w_head;
    brq_entry_t  w_alloc_entry;
    logic        w_run;
    logic        w_res_acc;
    logic        w_mispred;
    logic        w_alloc_fire;
    logic        w_err_set;

    assign w_run         = (r_state == StRun);
    assign o_alloc_ready = !w_full && w_run;

    assign w_res_acc = w_run && i_resolve_valid && !w_empty;
    assign w_mispred = w_res_acc && ((w_head.pred != i_resolve_taken) ||
                       (i_resolve_taken && (w_head.target != i_resolve_target)));

    // An allocation racing a mispredict is younger than the branch: squash it silently.
    assign w_alloc_fire = i_alloc_valid && o_alloc_ready && !w_mispred;
    assign w_err_set    = (i_alloc_valid && !o_alloc_ready && !w_mispred) ||
                          (w_run && i_resolve_valid && w_empty);

    assign w_alloc_entry = '{pc: i_alloc_pc, pred: i_alloc_pred,
                             target: i_alloc_target, cond: i_alloc_cond};

    brq_fifo u_brq_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_mispred),
        .i_push      (w_alloc_fire),
        .i_push_data (w_alloc_entry),
        .i_pop       (w_res_acc),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun:   if (w_mispred) w_state_nxt = StFlush;
            StFlush: w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StRun;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush     <= w_mispred;
            r_upd_valid <= w_res_acc && w_head.cond;
            if (w_mispred) begin
                r_redirect_pc <= i_resolve_target;
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
            if (w_res_acc) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_res_acc && w_head.cond) begin
                r_upd_pc    <= w_head.pc;
                r_upd_taken <= i_resolve_taken;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign o_flush       = r_flush;
    assign o_redirect_pc = r_redirect_pc;
    assign o_upd_valid   = r_upd_valid;
    assign o_upd_pc      = r_upd_pc;
    assign o_upd_taken   = r_upd_taken;
    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
    assign o_err         = r_err;

endmodule
